ldpc_sched: RTL and testbench
=============================

# ldpc_sched

Frame-level sequencer for the LDPC BER test harness. Sits between the noise-generator/quantizer buffer bank and `ldpc_core`. For each SNR point, it waits until the LLR buffers are full, loads them into the core, runs a decode with a cycle timeout, and counts residual bit errors in the decoded word (the all-zero codeword is transmitted). It accumulates results over a programmable number of frames, emits one report per SNR point, and steps `snr_idx` through the sweep.

## Interface
Parameters:
- `R`, 24, base-matrix columns
- `D`, 96, expansion factor; `DIM = R*D` decoded bits
- `SLICE`, 96, bits popcounted per cycle; must divide `DIM`
- `FRM_W`, 16, frame counter width
- `ERR_W`, 24, error accumulator width
- `TMO_W`, 12, timeout counter width

Ports:
- `clk` in 1: sole clock
- `rstn` in 1: reset, synchronous, active-low
- `start` in 1: begin sweep; sampled only in IDLE
- `snr_first` in 4: first SNR index
- `snr_last` in 4: last SNR index
- `frames` in FRM_W: frames per SNR point; 0 is treated as 1
- `tmo` in TMO_W: decode cycle limit; 0 disables the timeout
- `buf_full` in 1: AND of all generator buffer full flags
- `buf_clr` out 1: one-cycle pulse that resets the buffers and restarts fill
- `llr_load` out 1: one-cycle pulse that captures the buffer contents into the core LLR register
- `core_rst` out 1: core reset, active-high
- `core_en` out 1: core enable
- `core_term` in 1: core finished
- `core_res` in DIM: decoded hard bits
- `snr_idx` out 4: current SNR index to the quantizers
- `busy` out 1: high whenever the state is not IDLE
- `rpt_valid` out 1: one-cycle report strobe
- `rpt_snr` out 4: SNR index of the report
- `rpt_errs` out ERR_W: bit errors accumulated at this SNR
- `rpt_tmo` out FRM_W: frames at this SNR that ended by timeout
- `done` out 1: one-cycle pulse at the end of the sweep

## Operation
- States: IDLE, WAIT_BUF, LOAD, DECODE, COUNT, FRM_END, REPORT.
- IDLE: `core_rst`=1, `core_en`=0.
  - On `start`: `snr_idx`<=`snr_first`, clear all accumulators, go to WAIT_BUF.
  - If `snr_first`>`snr_last`, the sweep runs a single point at `snr_first`.
- WAIT_BUF: hold until `buf_full`=1, then go to LOAD.
- LOAD (1 cycle): `llr_load`=1, `buf_clr`=1, `core_rst`=1; clear the cycle counter.
  - Buffers refill while the core decodes.
- DECODE: `core_en`=1, `core_rst`=0; the cycle counter increments each cycle.
  - On `core_term`: latch `core_res` into the result register and go to COUNT.
  - On counter==`tmo` (with `tmo`≠0): latch `core_res`, increment the timeout count, go to COUNT.
  - If both occur in the same cycle, `core_term` wins and the frame is not counted as a timeout.
  - `core_term` is ignored in the first DECODE cycle.
- COUNT: `DIM/SLICE` cycles. Each cycle adds popcount(result[k*SLICE +: SLICE]) to the error accumulator; `k` runs 0 upward. The accumulator saturates at all-ones. `core_en`=0.
- FRM_END (1 cycle): frame count +1.
  - If frame count == max(`frames`,1): go to REPORT.
  - Otherwise: go to WAIT_BUF.
- REPORT (1 cycle): `rpt_valid`=1 with `rpt_*` equal to the accumulators. Then:
  - If `snr_idx`==`snr_last` or `snr_first`>`snr_last`: assert `done`, go to IDLE.
  - Otherwise: `snr_idx`+1, clear the accumulators and frame count, go to WAIT_BUF.
- `start` while busy is ignored. Parameter inputs are sampled only in IDLE on `start`; they are held in internal registers.

## Timing
- Reset (`rstn`=0 at an edge, from any state): state IDLE, `core_rst`=1.
  - All other outputs go to 0: `core_en`, `buf_clr`, `llr_load`, `busy`, `rpt_valid`, `rpt_*`, `done`, `snr_idx`.
  - Reset mid-decode abandons the frame; no report is issued.
- All outputs are registered.
- Cycle sequence:
  - `start` at edge t: WAIT_BUF from t+1.
  - `buf_full` high at t+1: LOAD at t+2, DECODE from t+3.
  - `core_term` at DECODE cycle n: COUNT for `DIM/SLICE` cycles, then FRM_END, then REPORT or WAIT_BUF.
- Per-frame overhead excluding the decode and the buffer wait: 1 (LOAD) + `DIM/SLICE` (COUNT) + 1 (FRM_END) cycles.
- The timeout fires at the DECODE cycle where the counter equals `tmo`, i.e. after `tmo` cycles of decode.

## Structure
- Package `ldpc_sched_pkg` holds:
  - the state enum
  - default widths FRM_W/ERR_W/TMO_W
  - the `SNR_W`=4 constant
- Sub-module `popcnt #(W)`: combinational adder tree over W bits, instantiated once with W=`SLICE`.
- The slice mux and saturating accumulator live in `ldpc_sched`.

## Test plan
- Single point, all-zero result: `snr_first`=`snr_last`=10, `frames`=3, `core_term` 5 cycles after each LOAD, `core_res`=0 → exactly one `rpt_valid` with `rpt_snr`=10, `rpt_errs`=0, `rpt_tmo`=0; `done` the following cycle.
- Error counting: `core_res` with bits 0, 95, 96 and 2303 set, `frames`=2 → `rpt_errs`=8; COUNT lasts 24 cycles per frame.
- Timeout: `tmo`=7, `core_term` never asserted → DECODE lasts exactly 7 cycles per frame; `frames`=4 → `rpt_tmo`=4. With `core_term` and the timeout in the same cycle → `rpt_tmo`=0.
- Sweep: `snr_first`=2, `snr_last`=5, `frames`=1 → four reports with `rpt_snr` 2, 3, 4, 5, accumulators cleared between points; `done` after the report for SNR 5. `snr_first`=6, `snr_last`=3 → one report at 6.
- Back-pressure and edges: hold `buf_full`=0 for 50 cycles → `llr_load` is not asserted and state stays in WAIT_BUF. `frames`=0 behaves as 1. `start` pulsed mid-sweep has no effect.
- Reset mid-decode: drop `rstn` for 1 cycle during DECODE → next cycle all outputs are at reset values and `core_rst`=1; no `rpt_valid` appears; a new `start` runs a clean sweep.

Source files
------------

// File: rtl/ldpc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_sched_pkg
// Purpose  : Shared state encoding and default widths for the LDPC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ldpc_sched_pkg;

    localparam int c_FRM_W = 16;
    localparam int c_ERR_W = 24;
    localparam int c_TMO_W = 12;
    localparam int c_SNR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUF = 3'd1,
        S_LOAD     = 3'd2,
        S_DECODE   = 3'd3,
        S_COUNT    = 3'd4,
        S_FRM_END  = 3'd5,
        S_REPORT   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ldpc_sched_popcnt.sv
`default_nettype none
// ============================================================================
// Module   : popcnt
// Purpose  : Combinational population count over a W-bit slice.
// Revision : 1.0 - initial release
// ============================================================================
module popcnt #(
    parameter int W  = 96,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_bits,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] w_sum;

    // Written as a chain; synthesis rebalances it into an adder tree.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < W; i++) begin
            w_sum = w_sum + CW'(i_bits[i]);
        end
    end

    assign o_cnt = w_sum;

endmodule
`default_nettype wire

// File: rtl/ldpc_sched.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_sched
// Purpose  : Frame sequencer for the LDPC BER harness: load, decode with
//            timeout, count residual bit errors and report per SNR point.
// Revision : 1.0 - initial release
// ============================================================================
module ldpc_sched
    import ldpc_sched_pkg::*;
#(
    parameter int R     = 24,
    parameter int D     = 96,
    parameter int SLICE = 96,
    parameter int FRM_W = c_FRM_W,
    parameter int ERR_W = c_ERR_W,
    parameter int TMO_W = c_TMO_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [c_SNR_W-1:0] snr_first,
    input  logic [c_SNR_W-1:0] snr_last,
    input  logic [FRM_W-1:0]   frames,
    input  logic [TMO_W-1:0]   tmo,
    input  logic               buf_full,
    output logic               buf_clr,
    output logic               llr_load,
    output logic               core_rst,
    output logic               core_en,
    input  logic               core_term,
    input  logic [R*D-1:0]     core_res,
    output logic [c_SNR_W-1:0] snr_idx,
    output logic               busy,
    output logic               rpt_valid,
    output logic [c_SNR_W-1:0] rpt_snr,
    output logic [ERR_W-1:0]   rpt_errs,
    output logic [FRM_W-1:0]   rpt_tmo,
    output logic               done
);

    localparam int c_DIM  = R * D;
    localparam int c_NSL  = c_DIM / SLICE;
    localparam int c_K_W  = $clog2(c_NSL + 1);
    localparam int c_PC_W = $clog2(SLICE + 1);

    state_t             r_state, w_state_nxt;
    logic [c_SNR_W-1:0] r_snr_last, r_snr_idx;
    logic               r_single;
    logic [FRM_W-1:0]   r_frames, r_frm, r_tmo_cnt;
    logic [TMO_W-1:0]   r_tmo, r_cyc;
    logic               r_first;
    logic [c_DIM-1:0]   r_res;
    logic [c_K_W-1:0]   r_k;
    logic [ERR_W-1:0]   r_errs;

    logic               r_buf_clr, r_llr_load, r_core_rst, r_core_en, r_busy;
    logic               r_rpt_valid, r_done;
    logic [c_SNR_W-1:0] r_rpt_snr;
    logic [ERR_W-1:0]   r_rpt_errs;
    logic [FRM_W-1:0]   r_rpt_tmo;

    logic [TMO_W-1:0]   w_cyc_inc;
    logic [FRM_W-1:0]   w_frm_inc;
    logic               w_term, w_tmo_hit, w_last_snr, w_last_k;
    logic [SLICE-1:0]   w_slice;
    logic [c_PC_W-1:0]  w_pc;
    logic [ERR_W:0]     w_err_sum;

    assign w_cyc_inc  = r_cyc + TMO_W'(1);
    assign w_frm_inc  = r_frm + FRM_W'(1);
    assign w_term     = core_term && !r_first;
    assign w_tmo_hit  = (r_tmo != '0) && (w_cyc_inc == r_tmo);
    assign w_last_snr = r_single || (r_snr_idx == r_snr_last);
    assign w_last_k   = (r_k == c_K_W'(c_NSL - 1));
    assign w_slice    = r_res[int'(r_k) * SLICE +: SLICE];
    assign w_err_sum  = {1'b0, r_errs} + (ERR_W + 1)'(w_pc);

    popcnt #(.W(SLICE)) u_popcnt (
        .i_bits (w_slice),
        .o_cnt  (w_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_WAIT_BUF;
            S_WAIT_BUF: if (buf_full) w_state_nxt = S_LOAD;
            S_LOAD:     w_state_nxt = S_DECODE;
            S_DECODE:   if (w_term || w_tmo_hit) w_state_nxt = S_COUNT;
            S_COUNT:    if (w_last_k) w_state_nxt = S_FRM_END;
            S_FRM_END:  w_state_nxt = (w_frm_inc == r_frames) ? S_REPORT : S_WAIT_BUF;
            S_REPORT:   w_state_nxt = w_last_snr ? S_IDLE : S_WAIT_BUF;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_snr_last  <= '0;
            r_snr_idx   <= '0;
            r_single    <= 1'b0;
            r_frames    <= FRM_W'(1);
            r_frm       <= '0;
            r_tmo_cnt   <= '0;
            r_tmo       <= '0;
            r_cyc       <= '0;
            r_first     <= 1'b0;
            r_res       <= '0;
            r_k         <= '0;
            r_errs      <= '0;
            r_buf_clr   <= 1'b0;
            r_llr_load  <= 1'b0;
            r_core_rst  <= 1'b1;
            r_core_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_rpt_valid <= 1'b0;
            r_rpt_snr   <= '0;
            r_rpt_errs  <= '0;
            r_rpt_tmo   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Outputs are registered from the next state so they line up with it.
            r_buf_clr   <= (w_state_nxt == S_LOAD);
            r_llr_load  <= (w_state_nxt == S_LOAD);
            r_core_rst  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
            r_core_en   <= (w_state_nxt == S_DECODE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_rpt_valid <= (w_state_nxt == S_REPORT);
            r_done      <= (r_state == S_REPORT) && w_last_snr;
            r_first     <= (r_state == S_LOAD);

            if (w_state_nxt == S_REPORT) begin
                r_rpt_snr  <= r_snr_idx;
                r_rpt_errs <= r_errs;
                r_rpt_tmo  <= r_tmo_cnt;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_snr_idx  <= snr_first;
                        r_snr_last <= snr_last;
                        r_single   <= (snr_first > snr_last);
                        r_frames   <= (frames == '0) ? FRM_W'(1) : frames;
                        r_tmo      <= tmo;
                        r_frm      <= '0;
                        r_tmo_cnt  <= '0;
                        r_errs     <= '0;
                    end
                end
                S_LOAD: r_cyc <= '0;
                S_DECODE: begin
                    r_cyc <= w_cyc_inc;
                    if (w_term || w_tmo_hit) begin
                        r_res <= core_res;
                        r_k   <= '0;
                        if (!w_term) r_tmo_cnt <= r_tmo_cnt + FRM_W'(1);
                    end
                end
                S_COUNT: begin
                    r_errs <= w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
                    r_k    <= r_k + c_K_W'(1);
                end
                S_FRM_END: r_frm <= w_frm_inc;
                S_REPORT: begin
                    if (!w_last_snr) begin
                        r_snr_idx <= r_snr_idx + c_SNR_W'(1);
                        r_frm     <= '0;
                        r_tmo_cnt <= '0;
                        r_errs    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign buf_clr   = r_buf_clr;
    assign llr_load  = r_llr_load;
    assign core_rst  = r_core_rst;
    assign core_en   = r_core_en;
    assign snr_idx   = r_snr_idx;
    assign busy      = r_busy;
    assign rpt_valid = r_rpt_valid;
    assign rpt_snr   = r_rpt_snr;
    assign rpt_errs  = r_rpt_errs;
    assign rpt_tmo   = r_rpt_tmo;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldpc_sched
// Purpose  : Scoreboard bench for ldpc_sched with a behavioural core responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldpc_sched;

    localparam int R = 24, D = 96, SLICE = 96, DIM = R * D;
    localparam int FRM_W = 16, ERR_W = 24, TMO_W = 12;

    logic             clk = 1'b0;
    logic             rstn, start, buf_full, core_term;
    logic [3:0]       snr_first, snr_last;
    logic [FRM_W-1:0] frames;
    logic [TMO_W-1:0] tmo;
    logic [DIM-1:0]   core_res;
    logic             buf_clr, llr_load, core_rst, core_en, busy, rpt_valid, done;
    logic [3:0]       snr_idx, rpt_snr;
    logic [ERR_W-1:0] rpt_errs;
    logic [FRM_W-1:0] rpt_tmo;

    ldpc_sched #(.R(R), .D(D), .SLICE(SLICE), .FRM_W(FRM_W), .ERR_W(ERR_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .snr_first(snr_first), .snr_last(snr_last),
        .frames(frames), .tmo(tmo), .buf_full(buf_full), .buf_clr(buf_clr), .llr_load(llr_load),
        .core_rst(core_rst), .core_en(core_en), .core_term(core_term), .core_res(core_res),
        .snr_idx(snr_idx), .busy(busy), .rpt_valid(rpt_valid), .rpt_snr(rpt_snr),
        .rpt_errs(rpt_errs), .rpt_tmo(rpt_tmo), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       snr;
        logic [ERR_W-1:0] errs;
        logic [FRM_W-1:0] tmo;
        bit               last;
    } rpt_t;

    rpt_t sb[$];
    int   n_checks = 0, n_errors = 0, n_rpts = 0;
    int   term_delay = 0, dc = 0;
    int   dec_run = 0, last_dec_len = 0, since_dec = 0, gap_rpt = 0;
    bit   exp_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int snr, input int errs, input int tm, input bit last);
        rpt_t e;
        e.snr  = 4'(snr);
        e.errs = ERR_W'(errs);
        e.tmo  = FRM_W'(tm);
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic start_sweep(input int first, input int last, input int frm, input int tm);
        snr_first = 4'(first);
        snr_last  = 4'(last);
        frames    = FRM_W'(frm);
        tmo       = TMO_W'(tm);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        check_eq({tag, "_done"}, 64'(got), 64'd1);
        check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_core_rst"}, core_rst, 1);
        check_eq({tag, "_core_en"}, core_en, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_llr_buf"}, {llr_load, buf_clr}, 0);
        check_eq({tag, "_snr_idx"}, snr_idx, 0);
        check_eq({tag, "_rpt"}, {rpt_valid, rpt_snr, rpt_errs, rpt_tmo}, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    // Core model: asserts core_term on DECODE cycle term_delay (0 = never).
    initial begin
        core_term = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (core_en === 1'b1) dc++;
            else dc = 0;
            core_term = (core_en === 1'b1) && (term_delay != 0) && (dc == term_delay);
        end
    end

    // Report monitor and timing measurement.
    initial begin
        rpt_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || exp_done) check_eq("done_pulse", done, 64'(exp_done));
            exp_done = 0;
            if (rpt_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_rpt", rpt_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rpt_snr", rpt_snr, e.snr);
                    check_eq("rpt_errs", rpt_errs, e.errs);
                    check_eq("rpt_tmo", rpt_tmo, e.tmo);
                    exp_done = e.last;
                    n_rpts++;
                end
            end
            if (core_en === 1'b1) begin
                dec_run++;
                since_dec = 0;
            end else begin
                if (dec_run > 0) last_dec_len = dec_run;
                dec_run = 0;
                since_dec++;
            end
            if (rpt_valid === 1'b1) gap_rpt = since_dec;
        end
    end

    initial begin
        int loads, busy_lo, snap;
        rstn = 1'b0; start = 1'b0; buf_full = 1'b0;
        snr_first = '0; snr_last = '0; frames = '0; tmo = '0; core_res = '0;
        tick(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick(2);

        // Single point, clean frames, with first-transaction latency checks.
        buf_full = 1'b1; term_delay = 5; core_res = '0;
        push(10, 0, 0, 1);
        start_sweep(10, 10, 3, 0);
        check_eq("t1_wait_busy", busy, 1);
        check_eq("t1_wait_noload", llr_load, 0);
        check_eq("t1_snr_idx", snr_idx, 10);
        tick();
        check_eq("t1_load", {llr_load, buf_clr, core_rst, core_en}, 4'b1110);
        tick();
        check_eq("t1_decode", {llr_load, core_rst, core_en}, 3'b001);
        wait_done("t1", 500);
        check_eq("t1_dec_len", last_dec_len, 5);

        // Error counting across slice boundaries; COUNT length via report gap.
        core_res = '0;
        core_res[0] = 1'b1; core_res[95] = 1'b1; core_res[96] = 1'b1; core_res[DIM-1] = 1'b1;
        term_delay = 3;
        push(7, 8, 0, 1);
        start_sweep(7, 7, 2, 0);
        wait_done("t2", 500);
        check_eq("t2_count_gap", gap_rpt, 26);

        // Timeout only, then timeout coinciding with core_term.
        core_res = '0; term_delay = 0;
        push(0, 0, 4, 1);
        start_sweep(0, 0, 4, 7);
        wait_done("t3a", 500);
        check_eq("t3a_dec_len", last_dec_len, 7);
        term_delay = 7;
        push(15, 0, 0, 1);
        start_sweep(15, 15, 1, 7);
        wait_done("t3b", 300);

        // Sweep over four points, then a reversed range.
        core_res = '0;
        core_res[5] = 1'b1; core_res[500] = 1'b1; core_res[2000] = 1'b1;
        term_delay = 2;
        for (int s = 2; s <= 5; s++) push(s, 3, 0, s == 5);
        start_sweep(2, 5, 1, 0);
        wait_done("t4a", 800);
        push(6, 3, 0, 1);
        start_sweep(6, 3, 1, 0);
        wait_done("t4b", 300);

        // Back-pressure, frames=0, ignored start and input changes while busy.
        buf_full = 1'b0; core_res = '0;
        push(1, 0, 0, 1);
        start_sweep(1, 1, 0, 0);
        snr_last = 4'd12; frames = FRM_W'(5);
        loads = 0; busy_lo = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                snr_first = 4'd9;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (llr_load === 1'b1) loads++;
            if (busy !== 1'b1) busy_lo++;
        end
        check_eq("t5_no_load", loads, 0);
        check_eq("t5_busy_held", busy_lo, 0);
        check_eq("t5_snr_idx", snr_idx, 1);
        buf_full = 1'b1;
        wait_done("t5", 300);

        // Reset in the middle of a decode.
        term_delay = 20;
        start_sweep(3, 3, 1, 0);
        for (int i = 0; i < 20 && core_en !== 1'b1; i++) tick();
        check_eq("t6_in_decode", core_en, 1);
        tick(3);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_reset_outputs("t6_rst");
        snap = n_rpts;
        tick(60);
        check_eq("t6_no_rpt", n_rpts, snap);
        core_res = '0; core_res[1000] = 1'b1; term_delay = 4;
        push(3, 2, 0, 1);
        start_sweep(3, 3, 2, 0);
        wait_done("t6", 500);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
